// File: rtl/ex_control_pipe.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ex_control_pipe : registered EX-stage control with multi-cycle shifts,    |
// |                   flush and sticky halt.                                  |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module ex_control_pipe #(
  parameter int OPW    = 5,
  parameter int ALUOPW = 5,
  parameter int MC_LAT = 4,
  parameter int MC_EN  = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OPW-1:0]    opcode,
  input  logic [1:0]        funct,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ALUOPW-1:0] ALUOp,
  output logic              ALUSrc,
  output logic [1:0]        ALUFunct,
  output logic              halt,
  output logic              busy,
  output logic              halted
);

  localparam int CNTW  = $clog2(MC_LAT + 1);
  localparam bit MC_ON = (MC_EN != 0) && (MC_LAT > 1);

  typedef enum logic [1:0] {EMPTY, BUSY, FULL, HALTED} state_t;

  state_t            state;
  logic [CNTW-1:0]   cnt;
  logic              upper_zero;
  logic [4:0]        op5;
  logic [ALUOPW-1:0] dec_aluop;
  logic              dec_src;
  logic [1:0]        dec_funct;
  logic              dec_halt;
  logic              dec_mc;
  logic              accept;

  // Opcode bits above the 5-bit decode space must be zero for a defined op.
  generate
    if (OPW > 5) begin : g_wide_op
      assign upper_zero = (opcode[OPW-1:5] == '0);
    end else begin : g_narrow_op
      assign upper_zero = 1'b1;
    end
  endgenerate

  assign op5 = opcode[4:0];

  always_comb begin
    dec_aluop = '0;
    dec_src   = 1'b0;
    dec_funct = 2'b00;
    dec_halt  = (opcode == '0);
    dec_mc    = 1'b0;
    if (upper_zero) begin
      if (op5 > 5'd3)
        dec_aluop = ALUOPW'(op5);
      dec_src = (op5 >= 5'd26);
      if (dec_src)
        dec_funct = funct;
      dec_mc = MC_ON && (op5 inside {[5'd20:5'd23], 5'd26});
    end
  end

  // A held HALT never lets a new op slip in behind it.
  assign in_ready = !flush &&
                    ((state == EMPTY) || ((state == FULL) && out_ready && !halt));
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= EMPTY;
      cnt       <= '0;
      ALUOp     <= '0;
      ALUSrc    <= 1'b0;
      ALUFunct  <= 2'b00;
      halt      <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      halted    <= 1'b0;
    end else if (flush && (state != HALTED)) begin
      state     <= EMPTY;
      cnt       <= '0;
      ALUOp     <= '0;
      ALUSrc    <= 1'b0;
      ALUFunct  <= 2'b00;
      halt      <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else if (accept) begin
      ALUOp    <= dec_aluop;
      ALUSrc   <= dec_src;
      ALUFunct <= dec_funct;
      halt     <= dec_halt;
      if (dec_mc) begin
        state     <= BUSY;
        cnt       <= CNTW'(MC_LAT - 1);
        busy      <= 1'b1;
        out_valid <= 1'b0;
      end else begin
        state     <= FULL;
        cnt       <= '0;
        busy      <= 1'b0;
        out_valid <= 1'b1;
      end
    end else begin
      case (state)
        BUSY: begin
          if (cnt == CNTW'(1)) begin
            state     <= FULL;
            cnt       <= '0;
            busy      <= 1'b0;
            out_valid <= 1'b1;
          end else begin
            cnt <= cnt - CNTW'(1);
          end
        end
        FULL: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (halt) begin
              state  <= HALTED;
              halted <= 1'b1;
            end else begin
              state <= EMPTY;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ex_control_pipe.sv
`default_nettype none
// Randomised and directed scoreboard bench for ex_control_pipe (OPW=6, MC_LAT=4).
module tb_ex_control_pipe;

  localparam int MC_LAT = 4;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [5:0] opcode;
  logic [1:0] funct;
  logic       flush;
  logic       out_valid;
  logic       out_ready;
  logic [5:0] ALUOp;
  logic       ALUSrc;
  logic [1:0] ALUFunct;
  logic       halt;
  logic       busy;
  logic       halted;

  ex_control_pipe #(.OPW(6), .ALUOPW(6), .MC_LAT(MC_LAT), .MC_EN(1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .funct(funct), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .ALUOp(ALUOp), .ALUSrc(ALUSrc), .ALUFunct(ALUFunct),
    .halt(halt), .busy(busy), .halted(halted)
  );

  typedef struct {
    int  aluop;
    int  src;
    int  fn;
    int  hlt;
    int  mc;
    int  rdy;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;
  bit   m_halted = 0;
  bit   post_flush = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference decode straight from the opcode table.
  function automatic exp_t model_decode(input int op, input int f);
    exp_t e;
    bit   defd;
    defd    = (op < 32);
    e.hlt   = (op == 0) ? 1 : 0;
    e.aluop = (defd && op > 3) ? op : 0;
    e.src   = (defd && op >= 26) ? 1 : 0;
    e.fn    = (e.src == 1) ? f : 0;
    e.mc    = (defd && ((op >= 20 && op <= 23) || op == 26)) ? 1 : 0;
    e.rdy   = 0;
    return e;
  endfunction

  // Monitor / scoreboard: samples mid-cycle, predicts what the next edge does.
  always @(negedge clk) begin
    bit   ev, eb, ei;
    exp_t e;
    if (!rst_n) begin
      q.delete();
      m_halted   = 0;
      post_flush = 0;
      chk("rst_out_valid", int'(out_valid), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_halted", int'(halted), 0);
      chk("rst_aluop", int'(ALUOp), 0);
    end else begin
      ev = 0;
      eb = 0;
      if (!m_halted && q.size() > 0) begin
        ev = (cyc >= q[0].rdy);
        eb = (q[0].mc == 1) && (cyc < q[0].rdy);
      end
      ei = !flush && !m_halted;
      if (ei && q.size() > 0)
        ei = ev && out_ready && (q[0].hlt == 0);
      chk("out_valid", int'(out_valid), int'(ev));
      chk("busy", int'(busy), int'(eb));
      chk("in_ready", int'(in_ready), int'(ei));
      chk("halted", int'(halted), int'(m_halted));
      if (ev) begin
        chk("aluop", int'(ALUOp), q[0].aluop);
        chk("alusrc", int'(ALUSrc), q[0].src);
        chk("alufunct", int'(ALUFunct), q[0].fn);
        chk("halt", int'(halt), q[0].hlt);
      end
      if (post_flush) begin
        chk("flush_clr", int'({ALUOp, ALUSrc, ALUFunct, halt}), 0);
        post_flush = 0;
      end
      if (flush && !m_halted) begin
        q.delete();
        post_flush = 1;
      end else begin
        if (ev && out_ready) begin
          e = q.pop_front();
          if (e.hlt == 1) m_halted = 1;
        end
        if (ei && in_valid) begin
          e = model_decode(int'(opcode), int'(funct));
          e.rdy = cyc + ((e.mc == 1) ? MC_LAT : 1);
          q.push_back(e);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int op, input int f);
    bit acc;
    acc      = 0;
    in_valid = 1'b1;
    opcode   = 6'(op);
    funct    = 2'(f);
    for (int k = 0; k < 64 && !acc; k++) begin
      @(negedge clk);
      acc = in_ready;
      step();
    end
    in_valid = 1'b0;
    chk("send_timeout", int'(acc), 1);
  endtask

  initial begin
    rst_n = 0; in_valid = 0; opcode = 0; funct = 0; flush = 0; out_ready = 1;
    repeat (2) step();
    rst_n = 1;
    step();

    // Back-to-back single-cycle stream: ADD, ADDI, SEQ.
    send(27, 1);
    send(8, 2);
    send(28, 0);
    step();

    // Multi-cycle SLLI.
    send(21, 0);
    repeat (5) step();

    // Backpressure: hold FULL three cycles with a pending op.
    out_ready = 0;
    send(27, 3);
    in_valid = 1; opcode = 6'd28; funct = 2'd2;
    repeat (3) step();
    out_ready = 1;
    send(28, 2);
    step();

    // Flush in BUSY with cnt=2 while another op is offered.
    send(21, 0);
    step();
    flush = 1; in_valid = 1; opcode = 6'd27; funct = 2'd1;
    step();
    flush = 0; in_valid = 0;
    step();
    send(27, 1);
    step();

    // Undefined wide opcode and the zero-ALUOp group.
    send(32, 1);
    send(3, 2);
    send(1, 0);
    send(63, 3);
    step();

    // Randomised traffic, no HALT.
    for (int i = 0; i < 1500; i++) begin
      int r;
      r = $urandom % 8;
      in_valid  = ($urandom % 4) != 0;
      funct     = 2'($urandom);
      case (r)
        0, 1: opcode = ($urandom % 2) ? 6'(20 + $urandom % 4) : 6'd26;
        2, 3: opcode = 6'(26 + $urandom % 6);
        4:    opcode = 6'(32 + $urandom % 32);
        5:    opcode = 6'(1 + $urandom % 3);
        default: opcode = 6'(1 + $urandom % 31);
      endcase
      out_ready = ($urandom % 4) != 0;
      flush     = ($urandom % 32) == 0;
      step();
    end
    in_valid = 0; flush = 0; out_ready = 1;
    repeat (8) step();

    // HALT: sticky, flush-proof, cleared only by reset.
    send(0, 0);
    repeat (3) step();
    flush = 1;
    step();
    flush = 0; in_valid = 1; opcode = 6'd27;
    repeat (4) step();
    in_valid = 0;
    rst_n = 0;
    step();
    rst_n = 1;
    step();

    // Reset in the middle of a multi-cycle op.
    send(26, 3);
    step();
    rst_n = 0;
    step();
    rst_n = 1;
    repeat (6) step();
    send(8, 0);
    repeat (3) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ex_control_pipe.md
# ex_control_pipe

Registered, parametrised EX-stage control unit. It sits between the ID/EX pipeline boundary and the EX datapath. It accepts one decoded instruction per valid/ready handshake and produces ALUOp/ALUSrc/ALUFunct. Shift/rotate-class instructions can be held for a configurable multi-cycle latency, and the unit supports pipeline flush and a sticky halt.

## Interface
Parameters:
- OPW, 5, opcode width
- ALUOPW, 5, ALUOp width (≥ OPW; opcode zero-extended into it)
- MC_LAT, 4, cycles from acceptance to out_valid for shift/rotate class (1 = single-cycle everywhere)
- MC_EN, 1, 1 enables multi-cycle handling, 0 treats all ops as single-cycle

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  instruction present from ID
- in_ready  out  1  unit accepts instruction this cycle (combinational)
- opcode  in  OPW  instruction opcode
- funct  in  2  R-format sub-op (instr[1:0])
- flush  in  1  synchronous kill of held/in-flight instruction
- out_valid  out  1  control outputs valid for EX
- out_ready  in  1  EX consumes this cycle
- ALUOp  out  ALUOPW  registered ALU operation
- ALUSrc  out  1  1 = second operand from register file (R-format)
- ALUFunct  out  2  registered funct (valid only when ALUSrc=1)
- halt  out  1  held instruction is HALT
- busy  out  1  multi-cycle op in progress
- halted  out  1  sticky: a HALT has been consumed

## Operation
- Decode (5-bit opcode, upper bits of wider OPW must be 0, else treated as undefined):
  - 00000 HALT, 00001 NOP, 00010 siic, 00011 RTI, undefined → ALUOp=0, ALUSrc=0
  - all other opcodes → ALUOp=opcode
  - ALUSrc=1 iff opcode ∈ {11010,11011,11100,11101,11110,11111}; else 0
  - ALUFunct=funct when ALUSrc=1, else 0
  - halt=1 iff opcode=00000
  - multi-cycle iff MC_EN=1, MC_LAT>1, opcode ∈ {10100..10111, 11010}
- States: EMPTY, BUSY, FULL, HALTED. Counter cnt width $clog2(MC_LAT+1).
- EMPTY: in_ready=1. On accept: latch decode. Multi-cycle → BUSY, cnt=MC_LAT-1. Else → FULL.
- BUSY: in_ready=0, out_valid=0, busy=1; cnt decrements each cycle; cnt==1 → FULL next edge.
- FULL: out_valid=1; in_ready=out_ready.
  - out_ready & halt → HALTED.
  - out_ready & in_valid → accept new (same rules as EMPTY).
  - out_ready only → EMPTY.
  - No out_ready → hold all outputs stable.
- HALTED: in_ready=0, out_valid=0, halted=1 until reset.
- flush (highest priority, any state except HALTED): next state EMPTY, out_valid=0, busy=0, cnt=0, outputs cleared to 0; in_ready forced 0 that cycle (no acceptance). Flush in HALTED ignored.

## Timing
- Reset (async, immediate): state EMPTY, ALUOp=0, ALUSrc=0, ALUFunct=0, halt=0, out_valid=0, busy=0, halted=0, cnt=0; in_ready=1 once rst_n high.
- Single-cycle op: accepted at edge N → out_valid high after edge N.
- Multi-cycle op: accepted at edge N → out_valid high after edge N+MC_LAT-1; busy high for MC_LAT-1 cycles.
- Full throughput (one op/cycle) for back-to-back single-cycle ops with out_ready=1.
- ALUOp/ALUSrc/ALUFunct/halt change only on acceptance, flush, or reset; stable while out_valid=1 & out_ready=0.
- Reset asserted mid-BUSY aborts the op; no output pulse.

## Test plan
- Reset then stream ADD (11011, funct=01), ADDI (01000), SEQ (11100) with out_ready=1 → out_valid 1 cycle after each accept; ALUOp 11011/01000/11100, ALUSrc 1/0/1, ALUFunct 01/00/00.
- MC_LAT=4: SLLI (10101) accepted edge 0 → busy cycles 1–3, in_ready=0, out_valid rises after edge 3 with ALUOp=10101.
- FULL with out_ready=0 for 3 cycles, in_valid=1 → in_ready=0, outputs stable; out_ready=1 → next op accepted same cycle.
- flush during BUSY (cnt=2) with in_valid=1 → next cycle EMPTY, out_valid=0, busy=0, nothing accepted; following op proceeds normally.
- HALT accepted then consumed → halted=1, in_ready=0 indefinitely; flush has no effect; rst_n low clears halted.
- Undefined opcode with OPW=6 (opcode 100000) and RTI (00011) → ALUOp=0, ALUSrc=0, halt=0.
